axi_burst_mem_slave: RTL and testbench
======================================

Name: axi_burst_mem_slave

Overview:
- AXI4 memory responder: the target end of the GPU AXI master port.
- Terminates the GPU master's write (AW/W/B) and read (AR/R) channels.
- Backs them with a local 64-bit-wide memory, with full INCR/FIXED burst support, byte strobes and error responses.
- Sits on the NoC side as the memory target that GPU masters write to and read back from.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data width; only 64 is supported
ID_W, 4, transaction ID width
MEM_BYTES, 8192, memory size in bytes; multiple of 8
BASE_ADDR, 32'h00000000, byte address mapped to memory word 0

Ports:
ACLK  in  1  clock, rising edge
ARESETn  in  1  reset; synchronous, active-low
S_AWID  in  ID_W  write ID
S_AWADDR  in  ADDR_W  write start address
S_AWLEN  in  8  beats-1
S_AWSIZE  in  3  beat size
S_AWBURST  in  2  burst type
S_AWVALID  in  1  AW valid
S_AWREADY  out  1  AW ready
S_WDATA  in  DATA_W  write data
S_WSTRB  in  DATA_W/8  byte strobes
S_WLAST  in  1  last write beat
S_WVALID  in  1  W valid
S_WREADY  out  1  W ready
S_BID  out  ID_W  response ID
S_BRESP  out  2  write response
S_BVALID  out  1  B valid
S_BREADY  in  1  B ready
S_ARID  in  ID_W  read ID
S_ARADDR  in  ADDR_W  read start address
S_ARLEN  in  8  beats-1
S_ARSIZE  in  3  beat size
S_ARBURST  in  2  burst type
S_ARVALID  in  1  AR valid
S_ARREADY  out  1  AR ready
S_RID  out  ID_W  read ID
S_RDATA  out  DATA_W  read data
S_RRESP  out  2  read response
S_RLAST  out  1  last read beat
S_RVALID  out  1  R valid
S_RREADY  in  1  R ready

Behaviour:
- Reset (ARESETn low at a rising edge):
  - All outputs go to 0; both FSMs return to IDLE.
  - Reset mid-burst abandons the burst; no B or R is issued for it.
  - Memory contents are retained. Memory is zero-initialised at time 0.
- Write FSM states: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: S_AWREADY=1. On AW handshake, latch ID, aligned address (addr & ~7), LEN, BURST and error class; go to W_DATA.
  - W_DATA: S_WREADY=1. Each W handshake writes the bytes whose WSTRB bit is set, then advances the beat counter.
    - Address step: INCR adds 8 per beat; FIXED holds the address.
    - After beat LEN+1 go to W_RESP with S_BVALID=1 on the next edge.
  - W_RESP: hold S_BID/S_BRESP/S_BVALID until S_BREADY; go to W_IDLE. S_AWREADY reasserts the cycle after the B handshake.
- Read FSM states: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: S_ARREADY=1. On AR handshake (cycle N), latch fields; S_RVALID=1 with beat 0 data at cycle N+1.
  - R_DATA: on each R handshake, present the next beat on the following edge. S_RLAST=1 only on beat LEN.
  - Under backpressure (S_RVALID=1, S_RREADY=0), S_RDATA/S_RID/S_RRESP/S_RLAST are held stable.
  - After the last beat handshake: S_RVALID=0 and back to R_IDLE. S_ARREADY reasserts the next cycle.
  - Peak throughput: one beat per cycle.
- The read and write FSMs are independent and run concurrently. Only one outstanding transaction per direction.
- Same-cycle read and write of the same word: the read beat returns the pre-write contents.
- Error classes, evaluated at the address handshake and applied to the whole burst:
  - DECERR (2'b11): any beat address outside [BASE_ADDR, BASE_ADDR+MEM_BYTES).
  - SLVERR (2'b10) if any of:
    - SIZE != 3
    - BURST == WRAP (2'b10) or reserved (2'b11)
    - INCR burst whose aligned start[11:0] + LEN*8 > 4095 (crosses a 4 KB boundary)
  - DECERR takes precedence over SLVERR.
  - Erroring write: all beats are accepted and discarded; no memory update.
  - Erroring read: the full LEN+1 beats are returned with RDATA=0 and RRESP=the error code.
- WLAST check: WLAST must be 1 exactly on beat LEN.
  - A mismatch on any beat makes BRESP=SLVERR; data is still written if the address is legal.
  - The burst length is governed by LEN, not by WLAST.
- Word index = (beat_addr - BASE_ADDR) >> 3. The unaligned low 3 address bits are ignored.
- Beat counter is 8 bits. LEN=255 is supported (256 beats).

Test Plan:
- Write 64'hFACE_CAFE_DEAD_BEEF to 0x1000 (LEN=0, SIZE=3, INCR) -> BRESP=00, BID echoed. Then read 0x1000 -> RVALID 1 cycle after AR handshake, RDATA=FACE_CAFE_DEAD_BEEF, RLAST=1, RRESP=00.
- Write a 4-beat INCR burst at 0x0100 with data 1,2,3,4, then read it back with RREADY toggling 1,0,1,0 -> beats 1,2,3,4 in order, data stable while stalled, RLAST only on beat 4.
- Word 0x0200 holds all-ones; write 0 with WSTRB=8'h0F -> readback 64'hFFFFFFFF_00000000.
- Write to 0x2000 (MEM_BYTES=8192) -> BRESP=11, memory unchanged. Read 0x2000 with LEN=1 -> 2 beats, RDATA=0, RRESP=11.
- FIXED burst, LEN=2, at 0x0300, data A,B,C -> read 0x0300 returns C. INCR burst at 0x0FF8 with LEN=1 -> SLVERR (4 KB crossing).
- Drop ARESETn for 1 cycle during beat 2 of a 4-beat write -> all valids/readies 0 next cycle, no B issued, AWREADY=1 after release, beats 0-1 retained in memory.

Source files
------------

// File: rtl/axi_burst_mem_slave.sv
// AXI4 memory target: independent write (AW/W/B) and read (AR/R) engines over a
// local 64-bit memory, with INCR/FIXED bursts, byte strobes and DECERR/SLVERR responses.
`timescale 1ns/1ps
module axi_burst_mem_slave #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W = 4,
  parameter int MEM_BYTES = 8192,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_W-1:0]     S_AWID,
  input  logic [ADDR_W-1:0]   S_AWADDR,
  input  logic [7:0]          S_AWLEN,
  input  logic [2:0]          S_AWSIZE,
  input  logic [1:0]          S_AWBURST,
  input  logic                S_AWVALID,
  output logic                S_AWREADY,
  input  logic [DATA_W-1:0]   S_WDATA,
  input  logic [DATA_W/8-1:0] S_WSTRB,
  input  logic                S_WLAST,
  input  logic                S_WVALID,
  output logic                S_WREADY,
  output logic [ID_W-1:0]     S_BID,
  output logic [1:0]          S_BRESP,
  output logic                S_BVALID,
  input  logic                S_BREADY,
  input  logic [ID_W-1:0]     S_ARID,
  input  logic [ADDR_W-1:0]   S_ARADDR,
  input  logic [7:0]          S_ARLEN,
  input  logic [2:0]          S_ARSIZE,
  input  logic [1:0]          S_ARBURST,
  input  logic                S_ARVALID,
  output logic                S_ARREADY,
  output logic [ID_W-1:0]     S_RID,
  output logic [DATA_W-1:0]   S_RDATA,
  output logic [1:0]          S_RRESP,
  output logic                S_RLAST,
  output logic                S_RVALID,
  input  logic                S_RREADY
);

  localparam int MEM_WORDS = MEM_BYTES / 8;
  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int XW = ADDR_W + 12;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;

  logic [DATA_W-1:0] mem [MEM_WORDS] = '{default: '0};

  // Error class of a whole burst, decided once from the address-phase fields.
  function automatic logic [1:0] err_class(input logic [ADDR_W-1:0] addr,
                                           input logic [7:0] len,
                                           input logic [2:0] size,
                                           input logic [1:0] burst);
    logic [XW-1:0] first;
    logic [XW-1:0] last;
    logic [XW-1:0] lo;
    logic [XW-1:0] hi;
    logic [12:0]   page_end;
    logic [1:0]    res;
    first    = {12'd0, addr & ~ADDR_W'(7)};
    last     = (burst == BURST_FIXED) ? first
                                      : first + {{(ADDR_W+1){1'b0}}, len, 3'b000};
    lo       = {12'd0, BASE_ADDR};
    hi       = lo + XW'(MEM_BYTES);
    page_end = {1'b0, first[11:0]} + {2'b00, len, 3'b000};
    if (first < lo || last >= hi)
      res = RESP_DECERR;
    else if (size != 3'd3 || burst[1] ||
             (burst == BURST_INCR && page_end > 13'd4095))
      res = RESP_SLVERR;
    else
      res = RESP_OKAY;
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 3);
  endfunction

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [1:0] burst);
    return (burst == BURST_FIXED) ? addr : addr + ADDR_W'(8);
  endfunction

  // ---------------- write engine ----------------
  w_state_t          w_state_q, w_state_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [ID_W-1:0]   w_id_q, w_id_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]        w_len_q, w_len_d;
  logic [1:0]        w_burst_q, w_burst_d;
  logic [1:0]        w_err_q, w_err_d;
  logic [7:0]        w_beat_q, w_beat_d;
  logic              wlast_bad_q, wlast_bad_d;
  logic [1:0]        aw_err;
  logic              w_last_beat;
  logic              w_bad;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_state_q   <= W_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= '0;
      w_id_q      <= '0;
      w_addr_q    <= '0;
      w_len_q     <= '0;
      w_burst_q   <= '0;
      w_err_q     <= '0;
      w_beat_q    <= '0;
      wlast_bad_q <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      w_id_q      <= w_id_d;
      w_addr_q    <= w_addr_d;
      w_len_q     <= w_len_d;
      w_burst_q   <= w_burst_d;
      w_err_q     <= w_err_d;
      w_beat_q    <= w_beat_d;
      wlast_bad_q <= wlast_bad_d;
    end
  end

  always_comb begin
    w_state_d   = w_state_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    w_id_d      = w_id_q;
    w_addr_d    = w_addr_q;
    w_len_d     = w_len_q;
    w_burst_d   = w_burst_q;
    w_err_d     = w_err_q;
    w_beat_d    = w_beat_q;
    wlast_bad_d = wlast_bad_q;
    mem_we      = 1'b0;
    mem_widx    = word_idx(w_addr_q);
    aw_err      = err_class(S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST);
    w_last_beat = (w_beat_q == w_len_q);
    w_bad       = wlast_bad_q | (S_WLAST != w_last_beat);
    unique case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (S_AWVALID && awready_q) begin
          awready_d   = 1'b0;
          wready_d    = 1'b1;
          w_id_d      = S_AWID;
          w_addr_d    = S_AWADDR & ~ADDR_W'(7);
          w_len_d     = S_AWLEN;
          w_burst_d   = S_AWBURST;
          w_err_d     = aw_err;
          w_beat_d    = 8'd0;
          wlast_bad_d = 1'b0;
          w_state_d   = W_DATA;
        end
      end
      W_DATA: begin
        if (S_WVALID && wready_q) begin
          mem_we      = (w_err_q == RESP_OKAY);
          wlast_bad_d = w_bad;
          // LEN alone ends the burst; a misplaced WLAST only taints the response.
          if (w_last_beat) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = w_id_q;
            bresp_d   = (w_err_q != RESP_OKAY) ? w_err_q :
                        (w_bad ? RESP_SLVERR : RESP_OKAY);
            w_state_d = W_RESP;
          end else begin
            w_beat_d = w_beat_q + 8'd1;
            w_addr_d = step_addr(w_addr_q, w_burst_q);
          end
        end
      end
      W_RESP: begin
        if (S_BREADY && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Memory survives reset, but a beat arriving during reset is dropped.
  always_ff @(posedge ACLK) begin
    if (ARESETn && mem_we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (S_WSTRB[b])
          mem[mem_widx][8*b +: 8] <= S_WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  r_state_t          r_state_q, r_state_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [7:0]        r_len_q, r_len_d;
  logic [1:0]        r_burst_q, r_burst_d;
  logic [1:0]        r_err_q, r_err_d;
  logic [7:0]        r_beat_q, r_beat_d;
  logic [1:0]        ar_err;
  logic [ADDR_W-1:0] ar_addr_al;
  logic [ADDR_W-1:0] r_next_addr;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rid_q     <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
      r_err_q   <= '0;
      r_beat_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_burst_q <= r_burst_d;
      r_err_q   <= r_err_d;
      r_beat_q  <= r_beat_d;
    end
  end

  // Read data is captured from the array at the same edge a write lands,
  // so a colliding read returns the pre-write word.
  always_comb begin
    r_state_d   = r_state_q;
    arready_d   = arready_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rid_d       = rid_q;
    r_addr_d    = r_addr_q;
    r_len_d     = r_len_q;
    r_burst_d   = r_burst_q;
    r_err_d     = r_err_q;
    r_beat_d    = r_beat_q;
    ar_err      = err_class(S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST);
    ar_addr_al  = S_ARADDR & ~ADDR_W'(7);
    r_next_addr = step_addr(r_addr_q, r_burst_q);
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (S_ARVALID && arready_q) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rlast_d   = (S_ARLEN == 8'd0);
          rdata_d   = (ar_err == RESP_OKAY) ? mem[word_idx(ar_addr_al)] : '0;
          rresp_d   = ar_err;
          rid_d     = S_ARID;
          r_addr_d  = ar_addr_al;
          r_len_d   = S_ARLEN;
          r_burst_d = S_ARBURST;
          r_err_d   = ar_err;
          r_beat_d  = 8'd0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_RREADY && rvalid_q) begin
          if (r_beat_q == r_len_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            r_beat_d = r_beat_q + 8'd1;
            r_addr_d = r_next_addr;
            rdata_d  = (r_err_q == RESP_OKAY) ? mem[word_idx(r_next_addr)] : '0;
            rlast_d  = ((r_beat_q + 8'd1) == r_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign S_AWREADY = awready_q;
  assign S_WREADY  = wready_q;
  assign S_BVALID  = bvalid_q;
  assign S_BID     = bid_q;
  assign S_BRESP   = bresp_q;
  assign S_ARREADY = arready_q;
  assign S_RVALID  = rvalid_q;
  assign S_RLAST   = rlast_q;
  assign S_RDATA   = rdata_q;
  assign S_RRESP   = rresp_q;
  assign S_RID     = rid_q;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Directed bench for axi_burst_mem_slave: a vector table of single-beat
// write/readback cases plus hand-written burst, stall, error and reset sequences.
`timescale 1ns/1ps
module tb_axi_burst_mem_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [3:0]  S_AWID = '0;
  logic [31:0] S_AWADDR = '0;
  logic [7:0]  S_AWLEN = '0;
  logic [2:0]  S_AWSIZE = '0;
  logic [1:0]  S_AWBURST = '0;
  logic        S_AWVALID = 1'b0;
  logic        S_AWREADY;
  logic [63:0] S_WDATA = '0;
  logic [7:0]  S_WSTRB = '0;
  logic        S_WLAST = 1'b0;
  logic        S_WVALID = 1'b0;
  logic        S_WREADY;
  logic [3:0]  S_BID;
  logic [1:0]  S_BRESP;
  logic        S_BVALID;
  logic        S_BREADY = 1'b0;
  logic [3:0]  S_ARID = '0;
  logic [31:0] S_ARADDR = '0;
  logic [7:0]  S_ARLEN = '0;
  logic [2:0]  S_ARSIZE = '0;
  logic [1:0]  S_ARBURST = '0;
  logic        S_ARVALID = 1'b0;
  logic        S_ARREADY;
  logic [3:0]  S_RID;
  logic [63:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RLAST;
  logic        S_RVALID;
  logic        S_RREADY = 1'b0;

  always #5 ACLK = ~ACLK;

  axi_burst_mem_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE),
    .S_AWBURST(S_AWBURST), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID),
    .S_WREADY(S_WREADY),
    .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
    .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;

  typedef struct {
    logic [31:0] wr_addr;
    logic [2:0]  wr_size;
    logic [1:0]  wr_burst;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [1:0]  exp_bresp;
    logic [31:0] rd_addr;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  vec_t        vecs [10];
  logic [63:0] beat_data [256];
  logic [63:0] exp_data [256];
  logic [1:0]  snap_bresp;
  logic [3:0]  snap_bid;
  int          checks_total = 0;
  int          checks_passed = 0;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // ch: 0=AWREADY 1=WREADY 2=BVALID 3=ARREADY; returns 1 ns after the handshake edge
  task automatic wait_handshake(input int ch);
    logic ok;
    for (int c = 0; c < 200; c++) begin
      @(negedge ACLK);
      case (ch)
        0: ok = S_AWREADY;
        1: ok = S_WREADY;
        2: ok = S_BVALID;
        3: ok = S_ARREADY;
        default: ok = 1'b0;
      endcase
      if (ok) begin
        if (ch == 2) begin
          snap_bresp = S_BRESP;
          snap_bid   = S_BID;
        end
        @(posedge ACLK); #1;
        return;
      end
    end
    checks_total++;
    $display("[TB] FAIL handshake_timeout_ch%0d: got no handshake, expected one within 200 cycles", ch);
  endtask

  task automatic apply_stimulus(input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst,
                                input logic [3:0] id, input logic [7:0] strb,
                                input logic bad_wlast, input logic [1:0] exp_bresp,
                                input string name);
    S_AWID = id; S_AWADDR = addr; S_AWLEN = len; S_AWSIZE = size; S_AWBURST = burst;
    S_AWVALID = 1'b1;
    wait_handshake(0);
    S_AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      S_WDATA  = beat_data[i];
      S_WSTRB  = strb;
      S_WLAST  = (i == int'(len)) || (bad_wlast && i == 0);
      S_WVALID = 1'b1;
      wait_handshake(1);
    end
    S_WVALID = 1'b0;
    S_WLAST  = 1'b0;
    S_BREADY = 1'b1;
    wait_handshake(2);
    S_BREADY = 1'b0;
    check_output({name, "_bresp"}, 64'(snap_bresp), 64'(exp_bresp));
    check_output({name, "_bid"}, 64'(snap_bid), 64'(id));
    check_output({name, "_awready_after_b"}, 64'(S_AWREADY), 64'd1);
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [3:0] id, input logic toggle,
                            input logic [1:0] exp_resp, input string name);
    int beats;
    S_ARID = id; S_ARADDR = addr; S_ARLEN = len; S_ARSIZE = size; S_ARBURST = burst;
    S_ARVALID = 1'b1;
    wait_handshake(3);
    S_ARVALID = 1'b0;
    check_output({name, "_rvalid_latency"}, 64'(S_RVALID), 64'd1);
    beats = 0;
    for (int cyc = 0; cyc < 1200 && beats <= int'(len); cyc++) begin
      S_RREADY = !toggle || (cyc % 2 == 0);
      @(negedge ACLK);
      if (S_RVALID) begin
        check_output($sformatf("%s_rdata%0d", name, beats), S_RDATA, exp_data[beats]);
        check_output($sformatf("%s_rresp%0d", name, beats), 64'(S_RRESP), 64'(exp_resp));
        check_output($sformatf("%s_rlast%0d", name, beats), 64'(S_RLAST),
                     64'(beats == int'(len)));
        check_output($sformatf("%s_rid%0d", name, beats), 64'(S_RID), 64'(id));
        if (S_RREADY) beats++;
      end
      @(posedge ACLK); #1;
    end
    S_RREADY = 1'b0;
    check_output({name, "_beats"}, 64'(beats), 64'(int'(len) + 1));
    check_output({name, "_rvalid_end"}, 64'(S_RVALID), 64'd0);
    check_output({name, "_arready_end"}, 64'(S_ARREADY), 64'd1);
  endtask

  initial begin
    vecs[0] = '{32'h1000, 3'd3, INCR,  64'hFACE_CAFE_DEAD_BEEF, 8'hFF, 2'b00, 32'h1000, 64'hFACE_CAFE_DEAD_BEEF, 2'b00};
    vecs[1] = '{32'h0200, 3'd3, INCR,  64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b00, 32'h0200, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00};
    vecs[2] = '{32'h0200, 3'd3, INCR,  64'h0,                   8'h0F, 2'b00, 32'h0200, 64'hFFFF_FFFF_0000_0000, 2'b00};
    vecs[3] = '{32'h2000, 3'd3, INCR,  64'h1234,                8'hFF, 2'b11, 32'h2000, 64'h0,                   2'b11};
    vecs[4] = '{32'h0FF8, 3'd3, INCR,  64'h55,                  8'hFF, 2'b00, 32'h0FF8, 64'h55,                  2'b00};
    vecs[5] = '{32'h0400, 3'd2, INCR,  64'hABCD,                8'hFF, 2'b10, 32'h0400, 64'h0,                   2'b00};
    vecs[6] = '{32'h0408, 3'd3, WRAP,  64'hABCD,                8'hFF, 2'b10, 32'h0408, 64'h0,                   2'b00};
    vecs[7] = '{32'h0505, 3'd3, INCR,  64'h0123_4567_89AB_CDEF, 8'hFF, 2'b00, 32'h0500, 64'h0123_4567_89AB_CDEF, 2'b00};
    vecs[8] = '{32'h1FF8, 3'd3, INCR,  64'h77,                  8'hFF, 2'b00, 32'h1FF8, 64'h77,                  2'b00};
    vecs[9] = '{32'h0410, 3'd3, RSVD,  64'hABCD,                8'hFF, 2'b10, 32'h0410, 64'h0,                   2'b00};

    repeat (3) @(posedge ACLK);
    #1;
    check_output("reset_awready", 64'(S_AWREADY), 64'd0);
    check_output("reset_wready",  64'(S_WREADY),  64'd0);
    check_output("reset_bvalid",  64'(S_BVALID),  64'd0);
    check_output("reset_arready", 64'(S_ARREADY), 64'd0);
    check_output("reset_rvalid",  64'(S_RVALID),  64'd0);
    check_output("reset_rdata",   S_RDATA,        64'd0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    check_output("release_awready", 64'(S_AWREADY), 64'd1);
    check_output("release_arready", 64'(S_ARREADY), 64'd1);

    for (int i = 0; i < 10; i++) begin
      beat_data[0] = vecs[i].wdata;
      apply_stimulus(vecs[i].wr_addr, 8'd0, vecs[i].wr_size, vecs[i].wr_burst, 4'(i),
                     vecs[i].wstrb, 1'b0, vecs[i].exp_bresp, $sformatf("vec%0d_wr", i));
      exp_data[0] = vecs[i].exp_rdata;
      read_burst(vecs[i].rd_addr, 8'd0, 3'd3, INCR, 4'(i + 3), 1'b0,
                 vecs[i].exp_rresp, $sformatf("vec%0d_rd", i));
    end

    // 4-beat INCR, read back with RREADY toggling to exercise stall stability.
    for (int i = 0; i < 4; i++) begin
      beat_data[i] = 64'(i + 1);
      exp_data[i]  = 64'(i + 1);
    end
    apply_stimulus(32'h0100, 8'd3, 3'd3, INCR, 4'hA, 8'hFF, 1'b0, 2'b00, "incr4_wr");
    read_burst(32'h0100, 8'd3, 3'd3, INCR, 4'hB, 1'b1, 2'b00, "incr4_rd");

    exp_data[0] = 64'h0; exp_data[1] = 64'h0;
    read_burst(32'h2000, 8'd1, 3'd3, INCR, 4'h2, 1'b0, 2'b11, "decerr_rd");

    beat_data[0] = 64'hA; beat_data[1] = 64'hB; beat_data[2] = 64'hC;
    apply_stimulus(32'h0300, 8'd2, 3'd3, FIXED, 4'h6, 8'hFF, 1'b0, 2'b00, "fixed_wr");
    exp_data[0] = 64'hC;
    read_burst(32'h0300, 8'd0, 3'd3, INCR, 4'h6, 1'b0, 2'b00, "fixed_rd");
    exp_data[0] = 64'h0;
    read_burst(32'h0308, 8'd0, 3'd3, INCR, 4'h6, 1'b0, 2'b00, "fixed_next_rd");
    exp_data[0] = 64'hC; exp_data[1] = 64'hC; exp_data[2] = 64'hC;
    read_burst(32'h0300, 8'd2, 3'd3, FIXED, 4'h7, 1'b0, 2'b00, "fixed_burst_rd");

    beat_data[0] = 64'h99; beat_data[1] = 64'h98;
    apply_stimulus(32'h0FF8, 8'd1, 3'd3, INCR, 4'h8, 8'hFF, 1'b0, 2'b10, "cross4k_wr");
    exp_data[0] = 64'h55;
    read_burst(32'h0FF8, 8'd0, 3'd3, INCR, 4'h8, 1'b0, 2'b00, "cross4k_keep_rd");
    exp_data[0] = 64'h0; exp_data[1] = 64'h0;
    read_burst(32'h0FF8, 8'd1, 3'd3, INCR, 4'h9, 1'b0, 2'b10, "cross4k_rd");

    beat_data[0] = 64'h71; beat_data[1] = 64'h72;
    apply_stimulus(32'h0700, 8'd1, 3'd3, INCR, 4'hC, 8'hFF, 1'b1, 2'b10, "badlast_wr");
    exp_data[0] = 64'h71; exp_data[1] = 64'h72;
    read_burst(32'h0700, 8'd1, 3'd3, INCR, 4'hC, 1'b0, 2'b00, "badlast_rd");

    // Reset lands while beat 2 of a 4-beat write is on the bus.
    S_AWID = 4'h5; S_AWADDR = 32'h0600; S_AWLEN = 8'd3; S_AWSIZE = 3'd3; S_AWBURST = INCR;
    S_AWVALID = 1'b1;
    wait_handshake(0);
    S_AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      S_WDATA = 64'(8'h11 * (i + 1)); S_WSTRB = 8'hFF; S_WLAST = 1'b0; S_WVALID = 1'b1;
      wait_handshake(1);
    end
    S_WDATA = 64'h33; S_WVALID = 1'b1; ARESETn = 1'b0;
    @(posedge ACLK); #1;
    check_output("midrst_awready", 64'(S_AWREADY), 64'd0);
    check_output("midrst_wready",  64'(S_WREADY),  64'd0);
    check_output("midrst_bvalid",  64'(S_BVALID),  64'd0);
    check_output("midrst_arready", 64'(S_ARREADY), 64'd0);
    check_output("midrst_rvalid",  64'(S_RVALID),  64'd0);
    ARESETn = 1'b1; S_WVALID = 1'b0;
    @(posedge ACLK); #1;
    check_output("midrst_awready_release", 64'(S_AWREADY), 64'd1);
    check_output("midrst_wready_release",  64'(S_WREADY),  64'd0);
    S_BREADY = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    check_output("midrst_no_b", 64'(S_BVALID), 64'd0);
    S_BREADY = 1'b0;
    exp_data[0] = 64'h11; exp_data[1] = 64'h22; exp_data[2] = 64'h0; exp_data[3] = 64'h0;
    read_burst(32'h0600, 8'd3, 3'd3, INCR, 4'h5, 1'b0, 2'b00, "midrst_rd");

    for (int i = 0; i < 256; i++) begin
      beat_data[i] = {32'hA5A5_0000 + 32'(i), 32'(i * 7)};
      exp_data[i]  = {32'hA5A5_0000 + 32'(i), 32'(i * 7)};
    end
    apply_stimulus(32'h1800, 8'd255, 3'd3, INCR, 4'hF, 8'hFF, 1'b0, 2'b00, "len255_wr");
    read_burst(32'h1800, 8'd255, 3'd3, INCR, 4'hE, 1'b0, 2'b00, "len255_rd");

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
